// File: rtl/share_recombiner_pkg.sv
// Ascon geometry shared by the unmasking blocks, plus widths derived for the
// share recombiner.
package ascon_params;
  localparam int PAR       = 1;
  localparam int d         = 2;
  localparam int COL_SIZE  = 5;
  localparam int ROW_W     = 64;
  localparam int NUM_BEATS = ROW_W / PAR;

  typedef enum logic {COLLECT = 1'b0, DONE = 1'b1} state_t;
endpackage

package share_recombiner_pkg;
  import ascon_params::*;

  localparam int NSH    = d + 1;
  localparam int BEAT_W = COL_SIZE * PAR;
  localparam int SH_W   = NSH * BEAT_W;
  localparam int OUT_W  = COL_SIZE * ROW_W;
  localparam int CNT_W  = $clog2(NUM_BEATS + 1);
  localparam int COL_IW = $clog2(ROW_W);
endpackage

// File: rtl/share_recombiner_if.sv
// Input share beats and unmasked-state output handshakes of the recombiner.
interface share_recombiner_if;
  import share_recombiner_pkg::*;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [SH_W-1:0]  shares_in_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [OUT_W-1:0] data_out_o;

  modport master (
    output in_valid_i, shares_in_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_out_o
  );
  modport slave (
    input  in_valid_i, shares_in_i, out_ready_i,
    output in_ready_o, out_valid_o, data_out_o
  );
endinterface

// File: rtl/share_recombiner_xor_reduce.sv
// Combinational (NSH)-way XOR of one beat of Boolean shares.
module share_xor_reduce #(
  parameter int NSH = 3,
  parameter int W   = 5
) (
  input  logic [NSH*W-1:0] i_shares,
  output logic [W-1:0]     o_beat
);
  always_comb begin
    o_beat = '0;
    for (int s = 0; s < NSH; s++) o_beat ^= i_shares[s*W +: W];
  end
endmodule

// File: rtl/share_recombiner.sv
// Two-stage unmasker: register a share beat, XOR-recombine it into the state
// accumulator, then present the full state once through valid/ready.
module share_recombiner
  import ascon_params::*;
  import share_recombiner_pkg::*;
(
  input logic               clk,
  input logic               rst,
  input logic               clear_i,
  share_recombiner_if.slave bus
);
  state_t                            r_state;
  logic [CNT_W-1:0]                  r_accept_cnt;
  logic [CNT_W-1:0]                  r_s1_idx;
  logic                              r_s1_valid;
  logic [SH_W-1:0]                   r_share_reg;
  logic [COL_SIZE-1:0][ROW_W-1:0]    r_acc;

  logic [BEAT_W-1:0] w_beat;
  logic [COL_IW-1:0] w_col_base;
  logic              w_accept;

  assign bus.in_ready_o  = (r_state == COLLECT) && (r_accept_cnt < CNT_W'(NUM_BEATS));
  assign bus.out_valid_o = (r_state == DONE);
  assign bus.data_out_o  = (r_state == DONE) ? r_acc : '0;
  assign w_accept        = bus.in_valid_i && bus.in_ready_o;
  assign w_col_base      = COL_IW'(r_s1_idx * CNT_W'(PAR));

  share_xor_reduce #(.NSH(NSH), .W(BEAT_W)) u_xor (
    .i_shares (r_share_reg),
    .o_beat   (w_beat)
  );

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_state      <= COLLECT;
      r_accept_cnt <= '0;
      r_s1_idx     <= '0;
      r_s1_valid   <= 1'b0;
      r_share_reg  <= '0;
      r_acc        <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_share_reg  <= bus.shares_in_i;
        r_s1_idx     <= r_accept_cnt;
        r_accept_cnt <= r_accept_cnt + 1'b1;
      end
      // Column j of the registered beat lands at state bit s1_idx*PAR+j of every row.
      if (r_s1_valid) begin
        for (int j = 0; j < PAR; j++)
          for (int r = 0; r < COL_SIZE; r++)
            r_acc[r][w_col_base + COL_IW'(j)] <= w_beat[j*COL_SIZE + r];
        if (r_s1_idx == CNT_W'(NUM_BEATS - 1)) r_state <= DONE;
      end
      if (r_state == DONE && bus.out_ready_i) begin
        r_state      <= COLLECT;
        r_accept_cnt <= '0;
        r_s1_valid   <= 1'b0;
        r_share_reg  <= '0;
        r_acc        <= '0;
      end
    end
  end
endmodule
